// File: rtl/pma_pll_reset_ctrl_pkg.sv
// Shared definitions for the PMA transmit PLL reset/lock sequencer:
// state encoding plus small constant helpers.
package pma_pll_reset_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_READY     = 2'd3
    } pll_state_t;

    localparam int RETRY_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Retry counter stops at all-ones instead of wrapping.
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pma_pll_reset_ctrl_sync.sv
// Two-flop synchronizer for asynchronous PMA status inputs; resets to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge, forming a real two-stage chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pma_pll_reset_ctrl.sv
// Reset and lock sequencer for the SFP PMA transmit PLL: holds the PLL in
// reset, waits for lock, qualifies it, and retries on timeout or lock loss.
module pma_pll_reset_ctrl
    import pma_pll_reset_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    output logic               pll_reset,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_count,
    output logic [1:0]         state
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic w_locked_s;

    pll_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pll_reset;
    logic               r_ready;
    logic               r_lock_lost;
    logic [RETRY_W-1:0] r_retry;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    // Outputs are assigned together with every state change, so they are
    // registered yet never lag the state register by a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_retry     <= '0;
        end else begin
            r_lock_lost <= 1'b0;
            case (r_state)
                ST_RESET: begin
                    if (r_cnt == RST_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state     <= ST_RESET;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        r_retry     <= sat_inc(r_retry);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (!w_locked_s) begin
                        r_state     <= ST_RESET;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        r_ready     <= 1'b0;
                        r_lock_lost <= 1'b1;
                        r_retry     <= sat_inc(r_retry);
                    end
                end
                default: begin
                    r_state     <= ST_RESET;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset   = r_pll_reset;
    assign ready       = r_ready;
    assign lock_lost   = r_lock_lost;
    assign retry_count = r_retry;
    assign state       = r_state;

endmodule
